// File: rtl/b11_decode.sv
// ---------------------------------------------------------------------------
// b11_decode
//
// Purpose:
//   Decoder for a shift-by-key letter cipher. Letters are coded 1..26, and the
//   decoder recovers p = ((c-1-k) mod 26) + 1. The control words 0 and 63 pass
//   through unchanged and advance the key, wrapping from 25 back to 0. Code
//   words 27..62 are invalid. They are dropped, err_flag pulses for one cycle,
//   and the key does not change.
//
//   One word is processed at a time through the states IDLE -> CHECK ->
//   (WRAP)* -> OUT. The mod-26 correction is done iteratively in WRAP, one
//   add of 26 per cycle, so a letter whose difference is negative takes one
//   extra cycle.
//
// Parameters:
//   KEY_INIT   key value loaded at reset (legal range 0..25)
//
// Ports:
//   clock      system clock; all state changes on its rising edge
//   reset      synchronous, active-low reset
//   in_data    6-bit encoded code word
//   in_valid   in_data is valid
//   in_ready   block can accept a word (IDLE only)
//   out_data   6-bit decoded plaintext word
//   out_valid  out_data is valid (OUT only)
//   out_ready  downstream accepts out_data
//   err_flag   one-cycle pulse marking a dropped invalid code word
//   err_cnt    (only with B11_DEC_ERRCNT_EN) 8-bit saturating count of
//              err_flag pulses, cleared by reset
//
// Configuration macro:
//   B11_DEC_ERRCNT_EN  adds the err_cnt port and its counter
// ---------------------------------------------------------------------------
module b11_decode #(
  parameter int unsigned KEY_INIT = 0
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [5:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [5:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       err_flag
`ifdef B11_DEC_ERRCNT_EN
  ,
  output logic [7:0] err_cnt
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    WRAP  = 2'd2,
    OUT   = 2'd3
  } state_t;

  localparam logic [4:0] KEY_RESET = 5'(KEY_INIT);
  localparam logic [4:0] KEY_MAX   = 5'd25;

  state_t            state;
  state_t            state_next;
  logic [5:0]        code_q;
  logic [5:0]        code_next;
  logic [4:0]        key_q;
  logic [4:0]        key_next;
  logic signed [6:0] diff_q;
  logic signed [6:0] diff_next;
  logic [5:0]        data_q;
  logic [5:0]        data_next;
  logic              err_q;
  logic              err_next;

  logic              is_control;
  logic              is_letter;

  // Classification of the captured code word
  assign is_control = (code_q == 6'd0) || (code_q == 6'd63);
  assign is_letter  = (code_q >= 6'd1) && (code_q <= 6'd26);

  // Next-state and datapath logic.
  // The difference c-1-k lies in -25..25. A single add of 26 therefore
  // always brings it into range, but WRAP stays generic and loops while
  // the difference is negative.
  always_comb begin
    state_next = state;
    code_next  = code_q;
    key_next   = key_q;
    diff_next  = diff_q;
    data_next  = data_q;
    err_next   = 1'b0;

    case (state)
      IDLE: begin
        if (in_valid) begin
          code_next  = in_data;
          state_next = CHECK;
        end
      end

      CHECK: begin
        if (is_control) begin
          data_next  = code_q;
          key_next   = (key_q < KEY_MAX) ? (key_q + 5'd1) : 5'd0;
          state_next = OUT;
        end else if (is_letter) begin
          diff_next  = $signed({1'b0, code_q}) - $signed({2'b00, key_q}) - 7'sd1;
          state_next = WRAP;
        end else begin
          err_next   = 1'b1;
          state_next = IDLE;
        end
      end

      WRAP: begin
        if (diff_q < 7'sd0) begin
          diff_next = diff_q + 7'sd26;
        end else begin
          data_next  = diff_q[5:0] + 6'd1;
          state_next = OUT;
        end
      end

      OUT: begin
        if (out_ready) begin
          state_next = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset discards any word in flight
  always_ff @(posedge clock) begin
    if (!reset) begin
      state  <= IDLE;
      code_q <= 6'd0;
      key_q  <= KEY_RESET;
      diff_q <= 7'sd0;
      data_q <= 6'd0;
      err_q  <= 1'b0;
    end else begin
      state  <= state_next;
      code_q <= code_next;
      key_q  <= key_next;
      diff_q <= diff_next;
      data_q <= data_next;
      err_q  <= err_next;
    end
  end

  // Outputs are gated by reset so they read 0 during any cycle in which
  // reset is held low, even before the first reset edge has been seen.
  assign in_ready  = reset && (state == IDLE);
  assign out_valid = reset && (state == OUT);
  assign out_data  = reset ? data_q : 6'd0;
  assign err_flag  = reset && err_q;

`ifdef B11_DEC_ERRCNT_EN
  logic [7:0] err_cnt_q;

  // Counts on the same edge that raises err_flag; saturates at 255
  always_ff @(posedge clock) begin
    if (!reset) begin
      err_cnt_q <= 8'd0;
    end else if (err_next && (err_cnt_q != 8'hFF)) begin
      err_cnt_q <= err_cnt_q + 8'd1;
    end
  end

  assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_b11_decode.sv
// ---------------------------------------------------------------------------
// tb_b11_decode
//
// Purpose:
//   Self-checking bench for b11_decode. Each valid word that is sent pushes
//   its expected plaintext and latency onto a scoreboard queue. The entry is
//   popped when out_valid appears. Latency counts cycles from the cycle in
//   which the word is presented with in_ready high (cycle 0) to the first
//   cycle with out_valid high.
//
// Ports: none (top-level bench)
// ---------------------------------------------------------------------------
module tb_b11_decode;

  localparam int KEY_INIT = 0;

  logic       clock = 1'b0;
  logic       reset;
  logic [5:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [5:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       err_flag;
`ifdef B11_DEC_ERRCNT_EN
  logic [7:0] err_cnt;
`endif

  b11_decode #(.KEY_INIT(KEY_INIT)) dut (
    .clock    (clock),
    .reset    (reset),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .err_flag (err_flag)
`ifdef B11_DEC_ERRCNT_EN
    ,
    .err_cnt  (err_cnt)
`endif
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [5:0] data;
    int         latency;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   n_fail   = 0;
  int   model_key;
  int   model_err_cnt;

  task automatic check_val(input string tag, input logic [31:0] observed,
                           input logic [31:0] expected);
    n_checks++;
    assert (observed === expected) n_pass++;
    else begin
      n_fail++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Reference decoder written straight from the cipher definition
  task automatic model_word(input int code, output exp_t e);
    int d;
    if (code == 0 || code == 63) begin
      e.data    = 6'(code);
      e.latency = 2;
      model_key = (model_key < 25) ? model_key + 1 : 0;
    end else begin
      d         = code - 1 - model_key;
      e.latency = (d < 0) ? 4 : 3;
      e.data    = 6'(((d + 26) % 26) + 1);
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(negedge clock);
    check_val("rst_in_ready", 32'(in_ready), 0);
    check_val("rst_out_valid", 32'(out_valid), 0);
    check_val("rst_out_data", 32'(out_data), 0);
    check_val("rst_err_flag", 32'(err_flag), 0);
    reset = 1'b1;
    model_key = KEY_INIT;
    model_err_cnt = 0;
    exp_q.delete();
    @(negedge clock);
    check_val("post_rst_in_ready", 32'(in_ready), 1);
    check_val("post_rst_out_valid", 32'(out_valid), 0);
`ifdef B11_DEC_ERRCNT_EN
    check_val("post_rst_err_cnt", 32'(err_cnt), 0);
`endif
  endtask

  // Called at a negedge; returns at the negedge just after the accept edge
  task automatic applyStimulus(input int code);
    exp_t e;
    int   waited = 0;
    while (in_ready !== 1'b1 && waited < 20) begin
      @(negedge clock);
      waited++;
    end
    check_val("in_ready_before_send", 32'(in_ready), 1);
    if (code <= 26 || code == 63) begin
      model_word(code, e);
      exp_q.push_back(e);
    end
    in_data  = 6'(code);
    in_valid = 1'b1;
    @(negedge clock);
    in_valid = 1'b0;
  endtask

  // Waits for out_valid, optionally holds out_ready low, then releases
  task automatic checkOutput(input int hold);
    exp_t e;
    int   cyc = 1;
    while (out_valid !== 1'b1 && cyc < 20) begin
      @(negedge clock);
      cyc++;
    end
    check_val("scoreboard_nonempty", 32'(exp_q.size() != 0), 1);
    if (exp_q.size() == 0) return;
    e = exp_q.pop_front();
    check_val("out_valid_seen", 32'(out_valid), 1);
    check_val("latency", 32'(cyc), 32'(e.latency));
    check_val("out_data", 32'(out_data), 32'(e.data));
    for (int i = 0; i < hold; i++) begin
      in_data  = 6'd17;
      in_valid = 1'b1;
      @(negedge clock);
      check_val("hold_out_valid", 32'(out_valid), 1);
      check_val("hold_out_data", 32'(out_data), 32'(e.data));
      check_val("hold_in_ready", 32'(in_ready), 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clock);
    out_ready = 1'b0;
    check_val("release_out_valid", 32'(out_valid), 0);
    check_val("release_in_ready", 32'(in_ready), 1);
  endtask

  task automatic send_invalid(input int code);
    applyStimulus(code);
    check_val("inv_check_err", 32'(err_flag), 0);
    check_val("inv_check_out_valid", 32'(out_valid), 0);
    @(negedge clock);
    model_err_cnt = (model_err_cnt < 255) ? model_err_cnt + 1 : 255;
    check_val("inv_err_pulse", 32'(err_flag), 1);
    check_val("inv_out_valid", 32'(out_valid), 0);
    check_val("inv_in_ready", 32'(in_ready), 1);
    @(negedge clock);
    check_val("inv_err_cleared", 32'(err_flag), 0);
    check_val("inv_no_out_valid", 32'(out_valid), 0);
`ifdef B11_DEC_ERRCNT_EN
    check_val("err_cnt", 32'(err_cnt), 32'(model_err_cnt));
`endif
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    reset     = 1'b0;
    in_data   = 6'd0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    model_key = KEY_INIT;
    model_err_cnt = 0;

    do_reset();

    // Key 0: letter passes through unchanged
    applyStimulus(5);  checkOutput(0);

    // Three control words advance the key to 3; then a wrap-around letter
    applyStimulus(0);  checkOutput(0);
    applyStimulus(0);  checkOutput(0);
    applyStimulus(0);  checkOutput(0);
    applyStimulus(2);  checkOutput(0);

    // Letter boundaries with key 3
    applyStimulus(3);  checkOutput(0);
    applyStimulus(4);  checkOutput(0);
    applyStimulus(1);  checkOutput(0);
    applyStimulus(26); checkOutput(0);

    // Invalid words at both edges of the range and in the middle
    send_invalid(27);
    send_invalid(62);
    send_invalid(40);
    applyStimulus(7);  checkOutput(0);

    // Downstream stall for 10 cycles with in_valid toggled on meanwhile
    applyStimulus(9);  checkOutput(10);

    // Twenty-six advances from key 0 return the key to 0
    do_reset();
    for (int i = 0; i < 26; i++) begin
      applyStimulus(63); checkOutput(0);
    end
    applyStimulus(7);  checkOutput(0);

    for (int i = 0; i < 6; i++) begin
      applyStimulus(int'($urandom_range(1, 26))); checkOutput(0);
    end

    // Reset in the middle of WRAP discards the word and restores KEY_INIT
    applyStimulus(0);  checkOutput(0);
    applyStimulus(0);  checkOutput(0);
    applyStimulus(1);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check_val("wrap_rst_out_valid", 32'(out_valid), 0);
    check_val("wrap_rst_in_ready", 32'(in_ready), 0);
    check_val("wrap_rst_out_data", 32'(out_data), 0);
    reset = 1'b1;
    exp_q.delete();
    model_key = KEY_INIT;
    model_err_cnt = 0;
    @(negedge clock);
    check_val("wrap_rst_idle", 32'(in_ready), 1);
    check_val("wrap_rst_no_out", 32'(out_valid), 0);
`ifdef B11_DEC_ERRCNT_EN
    check_val("wrap_rst_err_cnt", 32'(err_cnt), 0);
`endif
    applyStimulus(4);  checkOutput(0);
    applyStimulus(26); checkOutput(0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/b11_decode.md
B11_DECODE -- requirements
Module: b11_decode

Interface
REQ-001 The block SHALL have parameter KEY_INIT, default 0, meaning the key value loaded at reset (legal range 0..25).
REQ-002 The block SHALL have port clock  input  1  the single system clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset  input  1  synchronous, active-low reset (reset=0 sampled on a rising clock edge resets the block).
REQ-004 The block SHALL have port in_data  input  6  encoded code word.
REQ-005 The block SHALL have port in_valid  input  1  in_data is valid.
REQ-006 The block SHALL have port in_ready  output  1  block can accept a word.
REQ-007 The block SHALL have port out_data  output  6  decoded plaintext word.
REQ-008 The block SHALL have port out_valid  output  1  out_data is valid.
REQ-009 The block SHALL have port out_ready  input  1  downstream accepts out_data.
REQ-010 The block SHALL have port err_flag  output  1  one-cycle pulse marking an invalid code word that was dropped.

Function
REQ-011 The cipher is shift-by-key: for plaintext p in 1..26 and key k, code c = ((p-1+k) mod 26)+1; the block SHALL recover p = ((c-1-k) mod 26)+1.
REQ-012 Control words 0 and 63 SHALL pass through unchanged and advance the key: k = (k<25) ? k+1 : 0.
REQ-013 Code words 27..62 are invalid; the block SHALL drop them, pulse err_flag for exactly one cycle, and leave the key unchanged.
REQ-014 FSM states SHALL be IDLE, CHECK, WRAP, OUT; no other reachable states; any illegal encoding SHALL return to IDLE on the next edge.
REQ-015 IDLE: in_ready=1; an edge with in_valid=1 SHALL register in_data and go to CHECK; in_valid=0 stays in IDLE.
REQ-016 CHECK: control word -> out_data=c, key advance, go to OUT; letter -> d = c-1-k as signed 7-bit, go to WRAP; invalid -> err_flag=1 next cycle, go to IDLE.
REQ-017 WRAP: while d<0, d = d+26 and stay in WRAP; else out_data=d+1 (6-bit), go to OUT.
REQ-018 OUT: out_valid=1, out_data stable; the edge with out_ready=1 SHALL go to IDLE; out_ready=0 holds OUT indefinitely.
REQ-019 in_ready SHALL be 1 only in IDLE; in_valid in any other state SHALL be ignored.
REQ-020 Latency from the accepting edge to the cycle out_valid first goes high SHALL be 2 cycles for control words and 3 cycles for letters (one WRAP iteration), plus 1 per extra WRAP iteration.
REQ-021 Key SHALL be a 5-bit register, modified only in CHECK on a control word.

Reset
REQ-022 On reset=0, the block SHALL enter IDLE, load key=KEY_INIT, and drive out_data=0, out_valid=0, err_flag=0, in_ready=0 in the cycle of reset and 1 from the first non-reset cycle.
REQ-023 Reset SHALL take priority over all activity, including mid-WRAP and a pending OUT word, which is discarded.

Configuration
REQ-024 Macro B11_DEC_ERRCNT_EN SHALL, when defined, add output port err_cnt (8 bits) counting err_flag pulses, saturating at 255, cleared to 0 by reset.
REQ-025 Without B11_DEC_ERRCNT_EN the err_cnt port and counter SHALL be absent; all other behaviour is identical.

Verification
REQ-026 Reset, key=0, send 5 -> out_data=5, out_valid 3 cycles after accept.
REQ-027 Send 0,0,0 (outputs 0,0,0, key=3), then 2 -> out_data=25.
REQ-028 Send 63 twenty-six times -> key returns to 0; then send 7 -> out_data=7.
REQ-029 Send 40 -> err_flag one-cycle pulse, no out_valid, key unchanged; with B11_DEC_ERRCNT_EN, err_cnt=1.
REQ-030 Hold out_ready=0 for 10 cycles in OUT -> out_data stable, in_ready=0, in_valid ignored; release -> IDLE next edge.
REQ-031 Assert reset=0 during WRAP -> next cycle IDLE, out_valid=0, key=KEY_INIT.
